imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart of instruction_decoder and instruction_memory.
- Accepts instruction fields (opcode, register fields, immediate) over a valid/ready stream and packs them into 16-bit VR16 instruction words.
- Writes the packed words to sequential instruction-memory addresses and holds the core until the program image is loaded.
- Sits between the boot/debug source and the imem write port.

Parameters:
- ADDR_W, 16: imem address width; wrap at 2^ADDR_W.
- HOLD_AT_RESET, 1: reset value of core_hold (1 = core held until first load completes).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load; ignored unless IDLE.
- base_addr  in  ADDR_W  first write address, sampled on start.
- length  in  16  word count, sampled on start; 0 = unbounded, ends on in_last.
- in_valid  in  1  field set valid.
- in_ready  out  1  loader accepts this cycle.
- in_last  in  1  final word of image.
- in_fmt  in  2  encoding format: 0=R, 1=I, 2=D, 3=invalid.
- in_opcode, in_reg_a, in_reg_b, in_reg_c, in_reg_d, in_imm  in  4 each  instruction fields.
- imem_we  out  1  imem write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  16  packed instruction.
- busy  out  1  high in LOAD or FLUSH.
- done  out  1  one-cycle pulse when the final write is issued.
- core_hold  out  1  stall/reset request to program_counter.
- error  out  1  sticky error flag.
- word_count  out  16  words written in the current/last load.

Behaviour:
- Reset (sync, active-high): state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0, word_count=0, core_hold=HOLD_AT_RESET.
- Reset mid-load aborts the load; no further writes; words already written stay in imem.
- Packing:
  - Bits [15:12]=opcode, [11:8]=reg_a, [7:4]=reg_b in every format.
  - Bits [3:0]: fmt 0=reg_c, fmt 1=imm, fmt 2=reg_d.
  - fmt 3 writes 16'h0000 (NOP) and sets error.
- FSM states: IDLE, LOAD, FLUSH.
- IDLE:
  - On start: cur_addr<=base_addr, remaining<=length, word_count<=0, error<=0, core_hold<=1, go to LOAD.
- LOAD:
  - in_ready=1.
  - A transfer occurs when in_valid&in_ready.
  - On transfer, the next cycle drives imem_we=1, imem_addr=cur_addr, imem_wdata=packed word (1-cycle latency). cur_addr increments and word_count increments.
  - One write per cycle; back-to-back transfers give back-to-back writes.
  - Final transfer: (length!=0 and remaining==1) or in_last. On the final transfer, go to FLUSH.
  - If in_last arrives before the count runs out, it terminates the load early with no error.
- FLUSH:
  - in_ready=0; last imem_we is issued; done=1 this cycle.
  - core_hold<=0 from the next cycle; go to IDLE.
- Address wrap: accepting a word when cur_addr==all-ones writes at all-ones, wraps cur_addr to 0 and sets error (sticky until next start).
- A start pulse during LOAD or FLUSH is ignored.
- Simultaneous start and reset: reset wins.
- No-transfer cycles in LOAD: imem_we=0; imem_addr/imem_wdata hold their last values.
- word_count saturates at 16'hFFFF.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output checksum[15:0]: running XOR of every imem_wdata written, cleared on start and on reset.
  - Valid when done pulses; holds until the next start.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package vr16_pkg holds:
  - Field position constants (OPC_MSB=15, RA_MSB=11, RB_MSB=7, LOW_MSB=3).
  - Format codes FMT_R/FMT_I/FMT_D/FMT_BAD.
  - Loader state encodings.
  - A pack function, reusable by later assembler/debug blocks.
- One sub-module: instr_encoder, combinational fields+fmt -> 16-bit word + bad_fmt flag. The loader registers its output.

Test Plan:
- Basic load: start, base_addr=0x0010, length=3; send R(1,2,3,4), I(5,1,0,imm=F), D(7,A,B,d=C) -> writes 0x1234@0x10, 0x510F@0x11, 0x7ABC@0x12. done pulses with the third imem_we; word_count=3; core_hold falls the next cycle.
- Backpressure and gaps: in_valid toggling 1,0,1,0 with length=2 -> exactly 2 writes, no duplicates; imem_we low in gap cycles.
- Early in_last: length=5, in_last on word 2 -> 2 writes, done, error=0, word_count=2.
- Bad format plus wrap: base_addr=0xFFFF, length=2, second word fmt=3 -> 0x????@0xFFFF, then 0x0000@0x0000; error=1.
- Reset mid-load: after 1 of 4 words, assert reset for 1 cycle -> IDLE; in_ready=0; core_hold=1; no further imem_we; a new start loads correctly.
- Checksum (with IMEM_LOADER_CHECKSUM_EN): words 0x1234, 0x510F -> checksum=0x433B at done.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared VR16 definitions: field positions, format codes, loader state
// encodings and the instruction pack function.
package vr16_pkg;

  localparam int OPC_MSB = 15;
  localparam int RA_MSB  = 11;
  localparam int RB_MSB  = 7;
  localparam int LOW_MSB = 3;

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_D   = 2'd2;
  localparam logic [1:0] FMT_BAD = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Low nibble depends on format; an invalid format packs to a NOP.
  function automatic logic [15:0] pack(
    input logic [1:0] fmt,
    input logic [3:0] opcode,
    input logic [3:0] reg_a,
    input logic [3:0] reg_b,
    input logic [3:0] reg_c,
    input logic [3:0] reg_d,
    input logic [3:0] imm
  );
    logic [15:0] word;
    word = 16'h0000;
    word[OPC_MSB -: 4] = opcode;
    word[RA_MSB -: 4]  = reg_a;
    word[RB_MSB -: 4]  = reg_b;
    case (fmt)
      FMT_R:   word[LOW_MSB -: 4] = reg_c;
      FMT_I:   word[LOW_MSB -: 4] = imm;
      FMT_D:   word[LOW_MSB -: 4] = reg_d;
      default: word = 16'h0000;
    endcase
    return word;
  endfunction

  function automatic logic is_bad_fmt(input logic [1:0] fmt);
    return (fmt == FMT_BAD);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Field stream into the loader plus the imem write port it drives.
interface imem_loader_if #(
  parameter int ADDR_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [1:0]        in_fmt;
  logic [3:0]        in_opcode;
  logic [3:0]        in_reg_a;
  logic [3:0]        in_reg_b;
  logic [3:0]        in_reg_c;
  logic [3:0]        in_reg_d;
  logic [3:0]        in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;

  modport master (
    output in_valid, in_last, in_fmt, in_opcode, in_reg_a, in_reg_b,
           in_reg_c, in_reg_d, in_imm,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_last, in_fmt, in_opcode, in_reg_a, in_reg_b,
           in_reg_c, in_reg_d, in_imm,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_instr_encoder.sv
// Combinational VR16 encoder: instruction fields + format -> 16-bit word.
module instr_encoder
  import vr16_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [3:0]  opcode,
  input  logic [3:0]  reg_a,
  input  logic [3:0]  reg_b,
  input  logic [3:0]  reg_c,
  input  logic [3:0]  reg_d,
  input  logic [3:0]  imm,
  output logic [15:0] word,
  output logic        bad_fmt
);

  // Pack fields and flag the reserved format.
  always_comb begin
    word    = pack(fmt, opcode, reg_a, reg_b, reg_c, reg_d, imm);
    bad_fmt = is_bad_fmt(fmt);
  end

endmodule

// File: rtl/imem_loader.sv
// Loads packed VR16 words into sequential imem addresses and holds the core
// until the image is in place. Optional checksum output: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import vr16_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       length,
  imem_loader_if.slave      bus,
  output logic              busy,
  output logic              done,
  output logic              core_hold,
  output logic              error,
  output logic [15:0]       word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  logic [1:0]        state_r;
  logic [ADDR_W-1:0] cur_addr_r;
  logic [15:0]       remaining_r;
  logic              bounded_r;
  logic [15:0]       packed_s;
  logic              bad_fmt_s;
  logic              xfer_s;
  logic              final_s;
  logic              wrap_s;

  instr_encoder u_enc (
    .fmt     (bus.in_fmt),
    .opcode  (bus.in_opcode),
    .reg_a   (bus.in_reg_a),
    .reg_b   (bus.in_reg_b),
    .reg_c   (bus.in_reg_c),
    .reg_d   (bus.in_reg_d),
    .imm     (bus.in_imm),
    .word    (packed_s),
    .bad_fmt (bad_fmt_s)
  );

  // Transfer qualification; a zero length means only in_last can end the load.
  always_comb begin
    xfer_s  = bus.in_valid & bus.in_ready;
    final_s = xfer_s & ((bounded_r & (remaining_r == 16'd1)) | bus.in_last);
    wrap_s  = xfer_s & (cur_addr_r == {ADDR_W{1'b1}});
  end

  assign busy = (state_r != ST_IDLE);

  // Load FSM, registered imem write port and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      cur_addr_r     <= {ADDR_W{1'b0}};
      remaining_r    <= 16'd0;
      bounded_r      <= 1'b0;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= {ADDR_W{1'b0}};
      bus.imem_wdata <= 16'h0000;
      done           <= 1'b0;
      error          <= 1'b0;
      word_count     <= 16'd0;
      core_hold      <= HOLD_AT_RESET;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum       <= 16'h0000;
`endif
    end else begin
      bus.imem_we <= 1'b0;
      done        <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r      <= ST_LOAD;
            cur_addr_r   <= base_addr;
            remaining_r  <= length;
            bounded_r    <= (length != 16'd0);
            word_count   <= 16'd0;
            error        <= 1'b0;
            core_hold    <= 1'b1;
            bus.in_ready <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum     <= 16'h0000;
`endif
          end
        end
        ST_LOAD: begin
          if (xfer_s) begin
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= cur_addr_r;
            bus.imem_wdata <= packed_s;
            cur_addr_r     <= cur_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            remaining_r    <= remaining_r - 16'd1;
            if (word_count != 16'hFFFF) begin
              word_count <= word_count + 16'd1;
            end
            if (bad_fmt_s || wrap_s) begin
              error <= 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum <= checksum ^ packed_s;
`endif
            // done is registered alongside the final write so both appear in FLUSH.
            if (final_s) begin
              state_r      <= ST_FLUSH;
              bus.in_ready <= 1'b0;
              done         <= 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          state_r   <= ST_IDLE;
          core_hold <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          bus.in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader; expected writes come from a
// field-level model of the packing/addressing rules.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic        core_hold;
  logic        error;
  logic [15:0] word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  imem_loader_if #(.ADDR_W(16)) bus ();

  imem_loader #(.ADDR_W(16), .HOLD_AT_RESET(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .core_hold  (core_hold),
    .error      (error),
    .word_count (word_count)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] fmt;
    logic [3:0] op, ra, rb, rc, rd, imm;
    logic       last;
  } word_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        last;
  } exp_t;

  word_t       stim_q[$];
  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic        model_err;
  logic [15:0] model_csum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t mk(input int fmt, input int op, input int ra, input int rb,
                               input int rc, input int rd, input int imm, input bit last);
    word_t w;
    w.fmt = 2'(fmt); w.op = 4'(op); w.ra = 4'(ra); w.rb = 4'(rb);
    w.rc = 4'(rc); w.rd = 4'(rd); w.imm = 4'(imm); w.last = last;
    return w;
  endfunction

  // Reference packing: opcode, reg_a, reg_b as hex digits 3..1, format-selected low digit.
  function automatic logic [15:0] ref_pack(input word_t w);
    int low;
    case (w.fmt)
      2'd0:    low = int'(w.rc);
      2'd1:    low = int'(w.imm);
      2'd2:    low = int'(w.rd);
      default: return 16'h0000;
    endcase
    return 16'(int'(w.op) * 4096 + int'(w.ra) * 256 + int'(w.rb) * 16 + low);
  endfunction

  task automatic drive_word(input word_t w);
    bus.in_valid  = 1'b1;
    bus.in_fmt    = w.fmt;
    bus.in_opcode = w.op;
    bus.in_reg_a  = w.ra;
    bus.in_reg_b  = w.rb;
    bus.in_reg_c  = w.rc;
    bus.in_reg_d  = w.rd;
    bus.in_imm    = w.imm;
    bus.in_last   = w.last;
  endtask

  // mode 0: no gaps, 1: valid alternates 1,0,1,0, 2: random gaps with stray start pulses
  task automatic run_load(input logic [15:0] base, input logic [15:0] len, input int mode,
                          output int n_out);
    int   i = 0;
    int   cyc = 0;
    int   guard = 0;
    int   k = 0;
    bit   fin = 1'b0;
    bit   gap;
    exp_t e;
    model_err  = 1'b0;
    model_csum = 16'h0000;
    @(negedge clk);
    base_addr = base; length = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!fin && guard < 200 && i < stim_q.size()) begin
      guard++;
      gap = (mode == 1) ? (cyc % 2 == 1) : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      cyc++;
      if (gap) begin
        bus.in_valid = 1'b0;
        if (mode == 2 && $urandom_range(0, 1) == 1) begin
          start = 1'b1;
          base_addr = 16'($urandom);
        end
      end else begin
        drive_word(stim_q[i]);
        check("in_ready_in_load", 32'(bus.in_ready), 32'd1);
        e.addr = 16'(int'(base) + i);
        e.data = ref_pack(stim_q[i]);
        fin    = ((len != 16'd0) && (i + 1 == int'(len))) || stim_q[i].last;
        e.last = fin;
        if (stim_q[i].fmt == 2'd3 || e.addr == 16'hFFFF) model_err = 1'b1;
        model_csum = model_csum ^ e.data;
        exp_q.push_back(e);
        i++;
      end
      @(negedge clk);
      start = 1'b0;
    end
    bus.in_valid = 1'b0;
    n_out = i;
    while (done !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("word_count", 32'(word_count), 32'(i));
    check("error_at_done", 32'(error), 32'(model_err));
    check("hold_at_done", 32'(core_hold), 32'd1);
    check("busy_at_done", 32'(busy), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'(model_csum));
`endif
    @(negedge clk);
    check("hold_released", 32'(core_hold), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("ready_after", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every write must match the head of the scoreboard queue.
  always @(negedge clk) begin
    exp_t e;
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(bus.imem_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("imem_addr", 32'(bus.imem_addr), 32'(e.addr));
        check("imem_wdata", 32'(bus.imem_wdata), 32'(e.data));
        check("done_with_write", 32'(done), 32'(e.last));
      end
    end else if (done === 1'b1) begin
      check("done_without_write", 32'(bus.imem_we), 32'd1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    n;
    word_t w;
    reset = 1'b1; start = 1'b0; base_addr = 16'h0000; length = 16'd0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_fmt = 2'd0;
    bus.in_opcode = 4'h0; bus.in_reg_a = 4'h0; bus.in_reg_b = 4'h0;
    bus.in_reg_c = 4'h0; bus.in_reg_d = 4'h0; bus.in_imm = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_imem_we", 32'(bus.imem_we), 32'd0);
    check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_imem_wdata", 32'(bus.imem_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_core_hold", 32'(core_hold), 32'd1);
    reset = 1'b0;

    // Basic three-format load
    stim_q = {mk(0, 1, 2, 3, 4, 0, 0, 0), mk(1, 5, 1, 0, 0, 0, 15, 0), mk(2, 7, 10, 11, 0, 12, 0, 0)};
    run_load(16'h0010, 16'd3, 0, n);

    // Backpressure with alternating valid
    stim_q = {mk(0, 3, 4, 5, 6, 0, 0, 0), mk(1, 9, 8, 7, 0, 0, 6, 0), mk(0, 1, 1, 1, 1, 0, 0, 0)};
    run_load(16'h0200, 16'd2, 1, n);
    check("gap_writes", 32'(n), 32'd2);

    // Early in_last
    stim_q = {mk(0, 1, 1, 1, 1, 0, 0, 0), mk(2, 2, 2, 2, 0, 3, 0, 1), mk(0, 4, 4, 4, 4, 0, 0, 0),
              mk(0, 5, 5, 5, 5, 0, 0, 0), mk(0, 6, 6, 6, 6, 0, 0, 0)};
    run_load(16'h0300, 16'd5, 0, n);
    check("early_last_words", 32'(n), 32'd2);
    check("early_last_error", 32'(error), 32'd0);

    // Bad format plus address wrap
    stim_q = {mk(0, 8, 9, 10, 11, 0, 0, 0), mk(3, 15, 15, 15, 15, 15, 15, 0)};
    run_load(16'hFFFF, 16'd2, 0, n);
    check("wrap_error_sticky", 32'(error), 32'd1);

    // Reset in the middle of a four-word load
    stim_q = {mk(0, 1, 2, 3, 4, 0, 0, 0), mk(0, 5, 6, 7, 8, 0, 0, 0)};
    @(negedge clk);
    base_addr = 16'h0100; length = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_word(stim_q[0]);
    exp_q.push_back('{addr: 16'h0100, data: ref_pack(stim_q[0]), last: 1'b0});
    @(negedge clk);
    reset = 1'b1;
    drive_word(stim_q[1]);
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_core_hold", 32'(core_hold), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_word_count", 32'(word_count), 32'd0);
    for (int c = 0; c < 3; c++) begin
      check("mid_rst_no_write", 32'(bus.imem_we), 32'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("mid_rst_queue", 32'(exp_q.size()), 32'd0);

    // Reload after reset; words 0x1234, 0x510F
    stim_q = {mk(0, 1, 2, 3, 4, 0, 0, 0), mk(1, 5, 1, 0, 0, 0, 15, 0)};
    run_load(16'h0400, 16'd2, 0, n);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("checksum_known", 32'(checksum), 32'h0000433B);
`endif

    // Randomized loads
    for (int r = 0; r < 30; r++) begin
      logic [15:0] base;
      logic [15:0] len;
      int          sel;
      sel  = $urandom_range(0, 3);
      base = (sel == 0) ? 16'hFFFE : (sel == 1) ? 16'hFFFF : 16'($urandom);
      len  = 16'($urandom_range(0, 6));
      stim_q = {};
      for (int j = 0; j < 8; j++) begin
        w = mk(($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 4) == 0);
        if (len == 16'd0 && j == 7) w.last = 1'b1;
        stim_q.push_back(w);
      end
      run_load(base, len, $urandom_range(0, 2), n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
